// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller_if
// Description : Bundle of decode flags, EX/MEM status and pipeline control
//               outputs exchanged between the pipeline and hazard_controller.
//               master = pipeline side (drives i_*), slave = controller side.
// Ports       : i_id_*  ID-stage decode flags and source registers
//               i_ex_*  EX-stage writeback flags and destination
//               i_br_taken, i_mem_req, i_mem_ready  resolution / memory status
//               o_*     stall, flush, bubble, pc-select, error, stall count
// Revision    : 1.0  initial release
// ============================================================================
interface hazard_controller_if #(
   parameter int REG_AW = 2,
   parameter int CNT_W  = 16
);
   logic              i_id_valid;
   logic              i_id_branch;
   logic              i_id_flush;
   logic [REG_AW-1:0] i_id_src_a;
   logic [REG_AW-1:0] i_id_src_b;
   logic              i_id_uses_b;
   logic              i_ex_regwrite;
   logic              i_ex_memtoreg;
   logic [REG_AW-1:0] i_ex_dst;
   logic              i_br_taken;
   logic              i_mem_req;
   logic              i_mem_ready;
   logic              o_pc_stall;
   logic              o_ifid_stall;
   logic              o_idex_stall;
   logic              o_exmem_stall;
   logic              o_ifid_flush;
   logic              o_idex_bubble;
   logic              o_pc_sel;
   logic              o_mem_err;
   logic [CNT_W-1:0]  o_stall_cnt;

   modport master (
      output i_id_valid, i_id_branch, i_id_flush, i_id_src_a, i_id_src_b,
             i_id_uses_b, i_ex_regwrite, i_ex_memtoreg, i_ex_dst, i_br_taken,
             i_mem_req, i_mem_ready,
      input  o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall,
             o_ifid_flush, o_idex_bubble, o_pc_sel, o_mem_err, o_stall_cnt
   );

   modport slave (
      input  i_id_valid, i_id_branch, i_id_flush, i_id_src_a, i_id_src_b,
             i_id_uses_b, i_ex_regwrite, i_ex_memtoreg, i_ex_dst, i_br_taken,
             i_mem_req, i_mem_ready,
      output o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall,
             o_ifid_flush, o_idex_bubble, o_pc_sel, o_mem_err, o_stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline sequencing controller for the 4-stage accumulator
//               CPU. Generates stall/bubble/flush/PC-select controls from
//               decode flags and EX/MEM status; holds branch resolution
//               across memory wait states; flags memory timeouts and counts
//               PC-stall cycles (saturating).
// Ports       : i_clk    clock, rising edge
//               i_rst_n  asynchronous active-low reset
//               bus      hazard_controller_if.slave (inputs i_*, outputs o_*)
// Revision    : 1.0  initial release
// ============================================================================
module hazard_controller #(
   parameter int REG_AW      = 2,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  wire                 i_clk,
   input  wire                 i_rst_n,
   hazard_controller_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_BR   = 2'd1,
      ST_MEMW = 2'd2
   } state_t;

   localparam logic [7:0]       c_TIMEOUT = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   logic             br_flush_q, br_flush_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q;

   logic w_load_use, w_mem_block;
   logic w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall;
   logic w_ifid_flush, w_idex_bubble, w_pc_sel;

   assign w_load_use = bus.i_id_valid & bus.i_ex_regwrite & bus.i_ex_memtoreg &
                       ((bus.i_ex_dst == bus.i_id_src_a) |
                        (bus.i_id_uses_b & (bus.i_ex_dst == bus.i_id_src_b)));
   assign w_mem_block = bus.i_mem_req & ~bus.i_mem_ready;

   always_comb begin
      state_d       = state_q;
      ret_d         = ret_q;
      br_flush_d    = br_flush_q;
      wait_cnt_d    = wait_cnt_q;
      mem_err_d     = mem_err_q;
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_idex_stall  = 1'b0;
      w_exmem_stall = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_pc_sel      = 1'b0;
      case (state_q)
         ST_MEMW: begin
            if (bus.i_mem_ready) begin
               state_d = ret_q;
            end else if (wait_cnt_q == c_TIMEOUT) begin
               // Access aborted: release the pipeline and remember the fault
               mem_err_d = 1'b1;
               state_d   = ret_q;
            end else begin
               {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'hF;
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: begin  // ST_RUN, ST_BR
            if (w_mem_block) begin
               // Freeze everything; resolution resumes after the wait
               {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'hF;
               ret_d      = state_q;
               state_d    = ST_MEMW;
               wait_cnt_d = 8'd1;
            end else if ((state_q == ST_BR) && bus.i_br_taken) begin
               // Taken branch squashes whatever sits in ID, including a branch
               w_pc_sel      = 1'b1;
               w_ifid_flush  = br_flush_q;
               w_idex_bubble = br_flush_q;
               state_d       = ST_RUN;
            end else if (w_load_use) begin
               w_pc_stall    = 1'b1;
               w_ifid_stall  = 1'b1;
               w_idex_bubble = 1'b1;
            end else if (bus.i_id_valid && bus.i_id_branch) begin
               br_flush_d = bus.i_id_flush;
               state_d    = ST_BR;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_RUN;
         ret_q       <= ST_RUN;
         br_flush_q  <= 1'b0;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         br_flush_q <= br_flush_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         if (w_pc_stall && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   // Controls are forced low while reset is held
   assign bus.o_pc_stall    = w_pc_stall    & i_rst_n;
   assign bus.o_ifid_stall  = w_ifid_stall  & i_rst_n;
   assign bus.o_idex_stall  = w_idex_stall  & i_rst_n;
   assign bus.o_exmem_stall = w_exmem_stall & i_rst_n;
   assign bus.o_ifid_flush  = w_ifid_flush  & i_rst_n;
   assign bus.o_idex_bubble = w_idex_bubble & i_rst_n;
   assign bus.o_pc_sel      = w_pc_sel      & i_rst_n;
   assign bus.o_mem_err     = mem_err_q;
   assign bus.o_stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Self-checking bench for hazard_controller with a behavioural
//               pipeline model (branch-pending flag, wait length, sticky
//               error, saturating stall count).
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_controller;

   localparam int TO = 15;
   localparam int CW = 4;

   typedef struct packed {
      logic       valid, branch, flush;
      logic [1:0] src_a, src_b;
      logic       uses_b, ex_rw, ex_m2r;
      logic [1:0] ex_dst;
      logic       taken, req, ready;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_controller_if #(.REG_AW(2), .CNT_W(CW)) bus ();

   hazard_controller #(.REG_AW(2), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model state: a branch waiting in EX, an outstanding memory wait
   bit m_br_pending, m_br_flush, m_in_wait, m_err;
   int m_wait_len, m_cnt;

   // Expected values for the cycle just driven
   logic [6:0]    e_ctl;
   logic [CW-1:0] e_cnt;
   logic          e_err;

   function automatic logic [6:0] dut_ctl();
      return {bus.o_pc_stall, bus.o_ifid_stall, bus.o_idex_stall, bus.o_exmem_stall,
              bus.o_ifid_flush, bus.o_idex_bubble, bus.o_pc_sel};
   endfunction

   function automatic void m_reset();
      m_br_pending = 0; m_br_flush = 0; m_in_wait = 0; m_err = 0;
      m_wait_len = 0; m_cnt = 0;
   endfunction

   function automatic void model_eval(stim_t s);
      bit pc, ifs, ids, exs, fl, bub, sel, lu;
      {pc, ifs, ids, exs, fl, bub, sel} = '0;
      e_cnt = CW'(m_cnt);
      e_err = m_err;
      if (!rst_n) begin
         m_reset();
         e_ctl = '0; e_cnt = '0; e_err = 1'b0;
         return;
      end
      lu = s.valid && s.ex_rw && s.ex_m2r &&
           (s.ex_dst == s.src_a || (s.uses_b && s.ex_dst == s.src_b));
      if (m_in_wait) begin
         if (s.ready) m_in_wait = 0;
         else if (m_wait_len == TO) begin m_in_wait = 0; m_err = 1; end
         else begin {pc, ifs, ids, exs} = 4'hF; m_wait_len++; end
      end else if (s.req && !s.ready) begin
         {pc, ifs, ids, exs} = 4'hF; m_in_wait = 1; m_wait_len = 1;
      end else if (m_br_pending && s.taken) begin
         sel = 1; fl = m_br_flush; bub = m_br_flush; m_br_pending = 0;
      end else if (lu) begin
         pc = 1; ifs = 1; bub = 1;
      end else if (s.valid && s.branch) begin
         m_br_pending = 1; m_br_flush = s.flush;
      end else begin
         m_br_pending = 0;
      end
      if (pc && m_cnt < (1 << CW) - 1) m_cnt++;
      e_ctl = {pc, ifs, ids, exs, fl, bub, sel};
   endfunction

   task automatic drive(stim_t s);
      bus.i_id_valid = s.valid;   bus.i_id_branch = s.branch; bus.i_id_flush = s.flush;
      bus.i_id_src_a = s.src_a;   bus.i_id_src_b = s.src_b;   bus.i_id_uses_b = s.uses_b;
      bus.i_ex_regwrite = s.ex_rw; bus.i_ex_memtoreg = s.ex_m2r; bus.i_ex_dst = s.ex_dst;
      bus.i_br_taken = s.taken;   bus.i_mem_req = s.req;      bus.i_mem_ready = s.ready;
   endtask

   // Apply one cycle of stimulus at the falling edge, settle, evaluate model
   task automatic step(stim_t s);
      @(negedge clk);
      drive(s);
      #1;
      model_eval(s);
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      return s;
   endfunction

   function automatic stim_t load_use(logic [1:0] dst, logic [1:0] sa, logic ub);
      stim_t s = '0;
      s.valid = 1; s.ex_rw = 1; s.ex_m2r = 1; s.ex_dst = dst; s.src_a = sa;
      s.uses_b = ub; s.src_b = 2'd3;
      return s;
   endfunction

   function automatic stim_t branch(logic fl);
      stim_t s = '0;
      s.valid = 1; s.branch = 1; s.flush = fl;
      return s;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(stim_t'(16'($urandom)));
         total++;
         if ({dut_ctl(), bus.o_stall_cnt, bus.o_mem_err} !== 12'h0) begin
            bad++;
            $display("FAIL reset ctl=%b cnt=%0d err=%b required all zero",
                     dut_ctl(), bus.o_stall_cnt, bus.o_mem_err);
         end
      end
      drive(idle());
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      stim_t s;
      step(load_use(2'd2, 2'd2, 1'b0));
      total++;
      if (dut_ctl() !== 7'b1100010 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL load_use ctl=%b required=%b", dut_ctl(), 7'b1100010);
      end
      s = load_use(2'd2, 2'd1, 1'b0);
      step(s);
      total++;
      if (dut_ctl() !== 7'b0 || bus.o_stall_cnt !== 4'd1 || bus.o_stall_cnt !== e_cnt) begin
         bad++; $display("FAIL load_use_none ctl=%b cnt=%0d required ctl=0 cnt=1",
                         dut_ctl(), bus.o_stall_cnt);
      end
      s.uses_b = 1; s.src_b = 2'd2;
      step(s);
      total++;
      if (dut_ctl() !== 7'b1100010 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL load_use_b ctl=%b required=%b", dut_ctl(), 7'b1100010);
      end
   endtask

   task automatic test_branch();
      stim_t s;
      step(branch(1'b1));
      total++;
      if (dut_ctl() !== 7'b0 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL br_capture ctl=%b required=0", dut_ctl());
      end
      s = idle(); s.taken = 1;
      step(s);
      total++;
      if (dut_ctl() !== 7'b0000111 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL br_taken ctl=%b required=%b", dut_ctl(), 7'b0000111);
      end
      step(s);  // back in RUN: a stray taken must do nothing
      total++;
      if (dut_ctl() !== 7'b0 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL br_after ctl=%b required=0", dut_ctl());
      end
      step(branch(1'b1));
      step(idle());
      total++;
      if (dut_ctl() !== 7'b0 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL br_not_taken ctl=%b required=0", dut_ctl());
      end
   endtask

   task automatic test_mem_wait_br();
      stim_t s;
      step(branch(1'b1));
      s = idle(); s.req = 1;
      for (int i = 0; i < 3; i++) begin
         step(s);
         total++;
         if (dut_ctl() !== 7'b1111000 || dut_ctl() !== e_ctl) begin
            bad++; $display("FAIL memwait_stall[%0d] ctl=%b required=%b", i, dut_ctl(), 7'b1111000);
         end
      end
      s.ready = 1;
      step(s);
      total++;
      if (dut_ctl() !== 7'b0 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL memwait_release ctl=%b required=0", dut_ctl());
      end
      s = idle(); s.taken = 1;
      step(s);
      total++;
      if (dut_ctl() !== 7'b0000111 || dut_ctl() !== e_ctl) begin
         bad++; $display("FAIL memwait_resolve ctl=%b required=%b", dut_ctl(), 7'b0000111);
      end
   endtask

   task automatic test_timeout();
      stim_t s = idle();
      s.req = 1;
      for (int i = 0; i <= TO; i++) begin
         step(s);
         total++;
         if (dut_ctl() !== ((i < TO) ? 7'b1111000 : 7'b0) || dut_ctl() !== e_ctl ||
             bus.o_mem_err !== 1'b0) begin
            bad++; $display("FAIL timeout[%0d] ctl=%b err=%b required ctl=%b err=0",
                            i, dut_ctl(), bus.o_mem_err, e_ctl);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(idle());
         total++;
         if (bus.o_mem_err !== 1'b1 || bus.o_mem_err !== e_err) begin
            bad++; $display("FAIL timeout_err[%0d] err=%b required=1", i, bus.o_mem_err);
         end
      end
   endtask

   task automatic test_saturation();
      stim_t s = idle();
      @(negedge clk); rst_n = 1'b0; drive(idle()); m_reset();
      #2; rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step(load_use(2'd1, 2'd1, 1'b0));
      step(idle());
      total++;
      if (bus.o_stall_cnt !== 4'd15 || bus.o_stall_cnt !== e_cnt) begin
         bad++; $display("FAIL saturate cnt=%0d required=15", bus.o_stall_cnt);
      end
      // Reset asserted in the middle of a memory wait clears immediately
      s.req = 1;
      step(s); step(s);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({dut_ctl(), bus.o_stall_cnt, bus.o_mem_err} !== 12'h0) begin
         bad++; $display("FAIL async_reset ctl=%b cnt=%0d err=%b required all zero",
                         dut_ctl(), bus.o_stall_cnt, bus.o_mem_err);
      end
      m_reset();
      drive(idle());
      @(negedge clk); rst_n = 1'b1;
      step(idle());
      total++;
      if (dut_ctl() !== 7'b0 || dut_ctl() !== e_ctl || bus.o_stall_cnt !== e_cnt) begin
         bad++; $display("FAIL post_reset ctl=%b cnt=%0d required ctl=0 cnt=%0d",
                         dut_ctl(), bus.o_stall_cnt, e_cnt);
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int i = 0; i < 400; i++) begin
         s = stim_t'(16'($urandom));
         s.req   = ($urandom_range(0, 3) == 0);
         s.ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 39) == 0) s.ready = 0;
         step(s);
         total++;
         if ({dut_ctl(), bus.o_stall_cnt, bus.o_mem_err} !== {e_ctl, e_cnt, e_err}) begin
            bad++;
            $display("FAIL random[%0d] ctl=%b cnt=%0d err=%b required ctl=%b cnt=%0d err=%b",
                     i, dut_ctl(), bus.o_stall_cnt, bus.o_mem_err, e_ctl, e_cnt, e_err);
         end
      end
   endtask

   initial begin
      drive(idle());
      m_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait_br();
      test_timeout();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
`default_nettype wire
